// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: CPU bytes are queued in a DEPTH-entry FIFO and
// serialised back-to-back with a configurable frame (data bits, parity, stop).
//
// Ports:
//   clk            system clock, rising edge
//   resetn         synchronous active-low reset
//   i_data         byte to send (bits above DATA_BITS-1 ignored)
//   i_valid        push request; accepted when i_valid & o_ready
//   o_ready        FIFO not full
//   o_level        bytes held in the FIFO (excludes the byte being shifted)
//   o_busy         FIFO non-empty or a frame in progress
//   o_overflow     sticky, set by a push while full
//   i_clr_overflow clears o_overflow (a simultaneous overflow event wins)
//   o_uart_tx      serial line, idle high
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned PARITY      = 0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [7:0]               i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_busy,
    output logic                     o_overflow,
    input  logic                     i_clr_overflow,
    output logic                     o_uart_tx
);

    localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned LW  = PW + 1;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned BW  = 3;

    localparam logic [7:0]    DATA_MASK  = 8'((1 << DATA_BITS) - 1);
    localparam logic          ODD_PARITY = (PARITY == 2);
    localparam logic          HAS_PARITY = (PARITY != 0);
    localparam logic [CW-1:0] BAUD_LOAD  = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic [CW-1:0]   baud_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [7:0]      shift;
    logic            par_bit;
    logic            tx;
    logic            busy;
    logic            overflow;

    logic            push;
    logic            pop;
    logic            baud_done;
    logic            last_stop;

    // Status and handshake
    assign o_ready    = (count != LW'(DEPTH));
    assign o_level    = count;
    assign o_busy     = busy;
    assign o_overflow = overflow;
    assign o_uart_tx  = tx;

    // Pop from IDLE, or on the final stop cycle so frames run gap-free
    assign push      = i_valid & o_ready;
    assign baud_done = (baud_cnt == '0);
    assign last_stop = (state == STOP) && baud_done && (bit_cnt == '0);
    assign pop       = (count != '0) && ((state == IDLE) || last_stop);

    // FIFO, status and transmit FSM; tx follows the state one cycle later
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= i_data & DATA_MASK;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                shift   <= mem[rd_ptr];
                // stored bytes are already masked to DATA_BITS
                par_bit <= (^mem[rd_ptr]) ^ ODD_PARITY;
            end
            count <= count + LW'(push) - LW'(pop);

            if (i_valid && !o_ready) begin
                overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                overflow <= 1'b0;
            end

            busy <= (state != IDLE) || (count != '0);

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        state    <= START;
                        baud_cnt <= BAUD_LOAD;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_done) begin
                        state    <= DATA;
                        baud_cnt <= BAUD_LOAD;
                        bit_cnt  <= BW'(DATA_BITS - 1);
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (baud_done) begin
                        baud_cnt <= BAUD_LOAD;
                        shift    <= shift >> 1;
                        if (bit_cnt == '0) begin
                            state   <= HAS_PARITY ? PAR : STOP;
                            bit_cnt <= BW'(STOP_BITS - 1);
                        end else begin
                            bit_cnt <= bit_cnt - BW'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                PAR: begin
                    tx <= par_bit;
                    if (baud_done) begin
                        state    <= STOP;
                        baud_cnt <= BAUD_LOAD;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_done) begin
                        if (bit_cnt != '0) begin
                            bit_cnt  <= bit_cnt - BW'(1);
                            baud_cnt <= BAUD_LOAD;
                        end else if (pop) begin
                            state    <= START;
                            baud_cnt <= BAUD_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
